// File: rtl/dot_product_pipelined_param.sv
// Purpose: N-lane unsigned weighted-sum pipeline with optional running accumulation and saturate/wrap output.
// Latency: 2 + log2(N) cycles from an accepted beat to out_valid; one beat per clock sustained.
// Backpressure: none; every in_valid beat is taken, and bubbles flow through as out_valid=0.
module dot_product_pipelined_param #(
    parameter int N   = 4,
    parameter int DW  = 16,
    parameter int OW  = 16,
    parameter int SAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [N*DW-1:0] i_data,
    input  logic [N*DW-1:0] weights,
    input  logic            acc_en,
    input  logic            acc_clear,
    output logic            out_valid,
    output logic [OW-1:0]   outputRes,
    output logic            overflow
);

    localparam int LG = $clog2(N);
    localparam int SW = 2*DW + LG;
    localparam int TW = SW + 1;
    // Sideband stages: input capture, product stage, then one per adder level.
    localparam int NS = LG + 2;
    localparam logic [TW-1:0] MAXV = (TW'(1) << OW) - TW'(1);

    logic [N*DW-1:0] data_q;
    logic [N*DW-1:0] wts_q;
    logic            vld_q [NS];
    logic            en_q  [NS];
    logic            clr_q [NS];

    // Heap-ordered adder tree: leaves N-1..2N-2 hold products, node i sums
    // children 2i+1 and 2i+2, root node 0 carries the full lossless sum.
    logic [SW-1:0]   node_q [2*N-1];
    logic [OW-1:0]   acc_q;

    logic [TW-1:0]   base_w;
    logic [TW-1:0]   total_w;
    logic            over_w;
    logic [OW-1:0]   res_w;
    logic            take_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            wts_q  <= '0;
            for (int s = 0; s < NS; s++) begin
                vld_q[s] <= 1'b0;
                en_q[s]  <= 1'b0;
                clr_q[s] <= 1'b0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                data_q   <= i_data;
                wts_q    <= weights;
                en_q[0]  <= acc_en;
                clr_q[0] <= acc_clear;
            end
            for (int s = 1; s < NS; s++) begin
                vld_q[s] <= vld_q[s-1];
                en_q[s]  <= en_q[s-1];
                clr_q[s] <= clr_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2*N-1; i++) begin
                node_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                node_q[N-1+k] <= SW'({{DW{1'b0}}, data_q[k*DW +: DW]} *
                                     {{DW{1'b0}}, wts_q[k*DW +: DW]});
            end
            for (int i = 0; i < N-1; i++) begin
                node_q[i] <= node_q[2*i+1] + node_q[2*i+2];
            end
        end
    end

    always_comb begin
        take_w  = en_q[NS-1] | clr_q[NS-1];
        base_w  = (clr_q[NS-1] || !en_q[NS-1]) ? '0 : TW'(acc_q);
        total_w = base_w + TW'(node_q[0]);
        over_w  = (total_w > MAXV);
        res_w   = (SAT != 0 && over_w) ? '1 : total_w[OW-1:0];
    end

    // Results hold their last valid value across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            outputRes <= '0;
            overflow  <= 1'b0;
            acc_q     <= '0;
        end else begin
            out_valid <= vld_q[NS-1];
            if (vld_q[NS-1]) begin
                outputRes <= res_w;
                overflow  <= over_w;
                if (take_w) begin
                    acc_q <= res_w;
                end
            end
        end
    end

endmodule

// File: tb/tb_dot_product_pipelined_param.sv
// Bench: three builds (N=4 saturating, N=4 wrapping, N=8/DW=8/OW=19) share one stimulus stream.
// Directed table rows carry hand-derived results; random beats are scored by an arithmetic model.
module tb_dot_product_pipelined_param;

    logic        clk = 1'b0;
    logic        rst, in_valid, acc_en, acc_clear;
    logic [63:0] i_data, weights;
    logic        ov0, ov1, ov2, of0, of1, of2;
    logic [15:0] r0, r1;
    logic [18:0] r2;

    always #5 clk = ~clk;

    dot_product_pipelined_param #(.N(4), .DW(16), .OW(16), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .i_data(i_data), .weights(weights),
        .acc_en(acc_en), .acc_clear(acc_clear), .out_valid(ov0), .outputRes(r0), .overflow(of0));

    dot_product_pipelined_param #(.N(4), .DW(16), .OW(16), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .i_data(i_data), .weights(weights),
        .acc_en(acc_en), .acc_clear(acc_clear), .out_valid(ov1), .outputRes(r1), .overflow(of1));

    dot_product_pipelined_param #(.N(8), .DW(8), .OW(19), .SAT(1)) dut_n8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .i_data(i_data), .weights(weights),
        .acc_en(acc_en), .acc_clear(acc_clear), .out_valid(ov2), .outputRes(r2), .overflow(of2));

    typedef struct {
        bit          rst;
        bit          vld;
        logic [63:0] d;
        logic [63:0] w;
        bit          en;
        bit          clr;
        bit          t4;
        logic [31:0] r0;
        bit          o0;
        logic [31:0] r1;
        bit          o1;
        bit          t8;
        logic [31:0] r2;
        bit          o2;
    } vec_t;

    bit              ev [3][4096];
    logic [31:0]     er [3][4096];
    bit              eo [3][4096];
    longint unsigned macc [3];
    logic [31:0]     last_r [3];
    bit              last_o [3];
    int              lat [3] = '{4, 4, 5};
    string           nm [3] = '{"sat4", "wrap4", "n8"};
    int              edge_n = 0;
    int              n_chk = 0;
    int              n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    endtask

    // Weighted sum straight from the lane definition; acc follows the post-clip result.
    function automatic void model(input int k, input logic [63:0] d, input logic [63:0] w,
                                  input bit en, input bit clr,
                                  output logic [31:0] r, output bit o);
        int n, dw, ow;
        bit sat;
        longint unsigned m, s, base, tot, mx, res;
        n   = (k == 2) ? 8 : 4;
        dw  = (k == 2) ? 8 : 16;
        ow  = (k == 2) ? 19 : 16;
        sat = (k != 1);
        m   = (64'd1 << dw) - 1;
        s   = 0;
        for (int i = 0; i < n; i++)
            s += ((d >> (i*dw)) & m) * ((w >> (i*dw)) & m);
        base = (clr || !en) ? 0 : macc[k];
        tot  = base + s;
        mx   = (64'd1 << ow) - 1;
        o    = (tot > mx);
        res  = sat ? (o ? mx : tot) : (tot & mx);
        if (en || clr) macc[k] = res;
        r = 32'(res);
    endfunction

    function automatic logic [63:0] pk4(input int a, input int b, input int c, input int e);
        return {16'(e), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic vec_t mk(input bit vld, input logic [63:0] d, input logic [63:0] w,
                                input bit en, input bit clr);
        vec_t v;
        v = '{rst: 1'b0, vld: vld, d: d, w: w, en: en, clr: clr, t4: 1'b0, r0: '0, o0: 1'b0,
              r1: '0, o1: 1'b0, t8: 1'b0, r2: '0, o2: 1'b0};
        return v;
    endfunction

    function automatic vec_t x4(input vec_t v, input logic [31:0] a, input bit ao,
                                input logic [31:0] b, input bit bo);
        vec_t t;
        t = v; t.t4 = 1'b1; t.r0 = a; t.o0 = ao; t.r1 = b; t.o1 = bo;
        return t;
    endfunction

    function automatic vec_t x8(input vec_t v, input logic [31:0] a, input bit ao);
        vec_t t;
        t = v; t.t8 = 1'b1; t.r2 = a; t.o2 = ao;
        return t;
    endfunction

    task automatic step(input vec_t v);
        logic [31:0] r, ar;
        bit          o;
        logic        av, ao;
        rst = v.rst; in_valid = v.vld; i_data = v.d; weights = v.w;
        acc_en = v.en; acc_clear = v.clr;
        @(posedge clk);
        edge_n++;
        for (int k = 0; k < 3; k++) begin
            if (v.rst) begin
                for (int x = 0; x <= 5; x++) ev[k][edge_n+x] = 1'b0;
                macc[k] = 0; last_r[k] = '0; last_o[k] = 1'b0;
            end else if (v.vld) begin
                model(k, v.d, v.w, v.en, v.clr, r, o);
                if (k == 0 && v.t4) begin r = v.r0; o = v.o0; end
                if (k == 1 && v.t4) begin r = v.r1; o = v.o1; end
                if (k == 2 && v.t8) begin r = v.r2; o = v.o2; end
                ev[k][edge_n+lat[k]] = 1'b1;
                er[k][edge_n+lat[k]] = r;
                eo[k][edge_n+lat[k]] = o;
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      begin av = ov0; ar = 32'(r0); ao = of0; end
            else if (k == 1) begin av = ov1; ar = 32'(r1); ao = of1; end
            else             begin av = ov2; ar = 32'(r2); ao = of2; end
            if (ev[k][edge_n]) begin last_r[k] = er[k][edge_n]; last_o[k] = eo[k][edge_n]; end
            chk({nm[k], " out_valid"}, 32'(av), 32'(ev[k][edge_n]));
            chk({nm[k], " outputRes"}, ar, last_r[k]);
            chk({nm[k], " overflow"},  32'(ao), 32'(last_o[k]));
        end
    endtask

    initial begin
        vec_t        tbl [18];
        vec_t        v;
        logic [63:0] a, wa, b, wb, c, wc, d, wd, f, z, one;
        rst = 1'b1; in_valid = 1'b0; i_data = '0; weights = '0; acc_en = 1'b0; acc_clear = 1'b0;
        a = pk4(1, 2, 3, 4);   wa = pk4(12, 6, 4, 3);
        b = pk4(2, 2, 2, 2);   wb = pk4(5, 5, 5, 5);
        c = pk4(1, 1, 1, 1);   wc = pk4(2, 5, 7, 9);
        d = pk4(0, 0, 5, 3);   wd = pk4(13, 5, 5, 4);
        f = '1; z = '0; one = pk4(1, 0, 0, 0);

        tbl[0]  = mk(0, z, z, 0, 0); tbl[0].rst = 1'b1;
        tbl[1]  = tbl[0];
        tbl[2]  = x4(mk(1, a, wa, 0, 0), 48, 0, 48, 0);
        tbl[3]  = x4(mk(1, b, wb, 0, 0), 40, 0, 40, 0);
        tbl[4]  = x4(mk(1, c, wc, 0, 0), 23, 0, 23, 0);
        tbl[5]  = x4(mk(1, d, wd, 0, 0), 37, 0, 37, 0);
        tbl[6]  = x4(mk(1, a, wa, 0, 0), 48, 0, 48, 0);
        tbl[7]  = mk(0, z, z, 0, 0);
        tbl[8]  = mk(0, z, z, 0, 0);
        tbl[9]  = x4(mk(1, b, wb, 0, 0), 40, 0, 40, 0);
        tbl[10] = x4(mk(1, a, wa, 0, 1), 48, 0, 48, 0);
        tbl[11] = x4(mk(1, b, wb, 1, 0), 88, 0, 88, 0);
        tbl[12] = x4(mk(1, c, wc, 1, 1), 23, 0, 23, 0);
        tbl[13] = x8(x4(mk(1, f, f, 0, 0), 32'hFFFF, 1, 32'h0004, 1), 520200, 0);
        tbl[14] = x8(x4(mk(1, f, f, 0, 1), 32'hFFFF, 1, 32'h0004, 1), 520200, 0);
        tbl[15] = x4(mk(1, one, one, 1, 0), 32'hFFFF, 1, 5, 0);
        tbl[16] = x4(mk(1, z, z, 1, 0), 32'hFFFF, 0, 5, 0);
        tbl[17] = x4(mk(1, z, z, 0, 0), 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) step(tbl[i]);

        // Two beats in flight, then a reset edge that also carries a beat: none may emerge.
        step(x4(mk(1, a, wa, 0, 0), 48, 0, 48, 0));
        step(x4(mk(1, b, wb, 0, 0), 40, 0, 40, 0));
        v = mk(1, c, wc, 0, 0); v.rst = 1'b1;
        step(v);
        for (int i = 0; i < 6; i++) step(mk(0, z, z, 0, 0));
        step(x4(mk(1, d, wd, 0, 0), 37, 0, 37, 0));
        for (int i = 0; i < 6; i++) step(mk(0, z, z, 0, 0));

        for (int i = 0; i < 400; i++) begin
            logic [63:0] rd, rw;
            rd = {$urandom, $urandom};
            rw = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 1) begin
                rd = rd & 64'h0F0F0F0F0F0F0F0F;
                rw = rw & 64'h0F0F0F0F0F0F0F0F;
            end
            v = mk($urandom_range(3, 0) != 0, rd, rw, $urandom_range(1, 0) == 1,
                   $urandom_range(7, 0) == 0);
            v.rst = ($urandom_range(63, 0) == 0);
            step(v);
        end
        for (int i = 0; i < 6; i++) step(mk(0, z, z, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dot_product_pipelined_param.md
# dot_product_pipelined_param

Parametrised, fully pipelined weighted-sum engine: N unsigned DW-bit data lanes × N DW-bit weights → one OW-bit result per valid beat. Successor to the fixed 4-lane, 16-bit cascaded summation pipeline. Adds a valid handshake, configurable lane count, optional running accumulation across beats, and saturate/wrap overflow handling. It sits in the datapath between operand staging registers and the result consumer, accepting one beat per clock.

## Interface
- N, default 4: lane count; power of two, ≥ 2.
- DW, default 16: data and weight width per lane, unsigned.
- OW, default 16: output width; 1 ≤ OW ≤ 2*DW+log2(N).
- SAT, default 1: 1 = saturate to 2^OW−1; 0 = wrap (truncate).

- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat qualifier for i_data/weights/acc_en/acc_clear.
- i_data  in  N*DW  lane k at bits [k*DW +: DW].
- weights  in  N*DW  lane k at bits [k*DW +: DW].
- acc_en  in  1  add this beat's sum to running accumulator.
- acc_clear  in  1  restart accumulation with this beat (overrides acc_en base).
- out_valid  out  1  outputRes/overflow valid this cycle.
- outputRes  out  OW  result.
- overflow  out  1  full-precision result exceeded 2^OW−1.

## Operation
- No backpressure; a beat is accepted every cycle in_valid=1. Inputs sampled only when in_valid=1; otherwise ignored.
- Stage M: register N products p[k] = i_data[k]*weights[k], 2*DW bits each, unsigned.
- Stages T1..T(log2 N): binary adder tree, one registered level per stage, widths grow by 1 bit per level; final sum S is 2*DW+log2(N) bits, lossless.
- Stage O (output): base = 0 if acc_clear=1 or acc_en=0, else acc_reg. total = base + S, computed with 1 extra bit. result = total, or 2^OW−1 if SAT=1 and total > 2^OW−1; else low OW bits. overflow = (total > 2^OW−1) regardless of SAT.
- acc_reg ← result (post-saturation/wrap) on every valid output beat where acc_en=1 or acc_clear=1; unchanged otherwise.
- acc_en/acc_clear travel down the pipeline with their beat (sideband shift registers), so they apply to their own beat's sum.
- Valid bit travels in a parallel shift register, depth L; bubbles propagate as out_valid=0.
- When out_valid=0, outputRes and overflow hold the last valid values.

## Timing
- Latency L = 2 + log2(N) cycles: beat sampled at edge t → out_valid=1 and result visible after edge t+L. N=4 → L=4.
- Throughput: 1 beat/cycle; back-to-back beats give back-to-back results in order.
- Reset (rst=1 at edge): all pipeline registers, sideband, acc_reg, outputRes, overflow = 0; out_valid = 0. In-flight beats are discarded. First beat accepted at first edge with rst=0.
- Reset mid-stream: no result from any beat sampled before or at the reset edge ever appears.
- acc_clear and acc_en both 1: result = S (clear wins for base), acc_reg ← result.
- Accumulation across bubbles: acc_reg persists across out_valid=0 cycles.
- Saturated accumulator: further acc_en beats keep result at 2^OW−1, overflow=1 (SAT=1); wraps modulo 2^OW (SAT=0).
- Zero operands on all lanes: result 0 (or acc_reg when accumulating), overflow=0.

## Test plan
- Back-to-back, N=4, DW=OW=16, SAT=1, acc_en=0: data/weights (1,2,3,4)/(12,6,4,3), (2,2,2,2)/(5,5,5,5), (1,1,1,1)/(2,5,7,9), (0,0,5,3)/(13,5,5,4) on 4 consecutive cycles → outputRes 48, 40, 23, 37 on 4 consecutive cycles starting L=4 cycles after the first, overflow=0.
- Bubbles: same first two beats separated by 2 cycles of in_valid=0 → out_valid pattern 1,0,0,1; outputRes holds 48 during the gap, then 40.
- Accumulation: beat A=48 with acc_clear=1, beat B=40 with acc_en=1, beat C=23 with acc_clear=1,acc_en=1 → 48, 88, 23.
- Overflow: all lanes 0xFFFF×0xFFFF; SAT=1 → 0xFFFF, overflow=1; SAT=0 build → 0x0004, overflow=1.
- Reset mid-flight: two beats issued, rst=1 for one cycle the edge after the second → out_valid stays 0 through L+2 cycles; outputRes=0; next beat after reset returns its correct sum at latency L.
- Parametric: N=8, DW=8, OW=19, all lanes 255×255 → 520200, overflow=0, L=5.
